// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Multi-channel input conditioner. Each channel synchronises an
//                asynchronous input, accepts a new level only after it has
//                persisted for DEBOUNCE_CYCLES synchronised cycles, and emits
//                registered one-cycle rise/fall strobes on each accepted change.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; it is cleared on accept.
  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // Channels are fully independent: one copy of the whole pipeline per bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic [c_cnt_w-1:0]     cnt_q;
    logic [c_cnt_w-1:0]     cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   w_sync;

    // Oldest synchroniser stage is the only one safe to use as a level.
    assign w_sync = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din[gi]};
      end
    end

    // Debounce decision: agreement clears the count, a full count accepts.
    always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (w_sync == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_cnt_last) begin
        dout_d = w_sync;
        cnt_d  = '0;
        rise_d = w_sync;
        fall_d = ~w_sync;
      end else begin
        cnt_d = cnt_q + c_cnt_one;
      end
    end

    // Register counter, level and strobes; reset overrides any pending accept.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        dout_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign dout[gi] = dout_q;
    assign rise[gi] = rise_q;
    assign fall[gi] = fall_q;

  end : g_ch

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Directed-vector bench for input_debouncer (WIDTH=2,
//                SYNC_STAGES=2, DEBOUNCE_CYCLES=4). Each row gives the inputs
//                applied before an edge and the outputs expected after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

  localparam int WIDTH           = 2;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  typedef struct packed {
    logic       rst;
    logic [1:0] din;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  int   n_checks;
  int   n_errors;
  vec_t vecs[$];

  input_debouncer #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] d, input logic [1:0] eo,
                     input logic [1:0] er, input logic [1:0] ef);
    vec_t v;
    v.rst  = r;
    v.din  = d;
    v.dout = eo;
    v.rise = er;
    v.fall = ef;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic r, input logic [1:0] d,
                       input logic [1:0] eo, input logic [1:0] er, input logic [1:0] ef);
    for (int k = 0; k < n; k++) add(r, d, eo, er, ef);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    din      = '0;

    // Reset: two reset edges, then first free edge, all quiet.
    add_n(2, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);            // 0-1
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 2
    // Clean step on ch0: rise 5 edges after input change, then fall likewise.
    add_n(5, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);            // 3-7
    add  (   1'b0, 2'b01, 2'b01, 2'b01, 2'b00);            // 8
    add_n(4, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);            // 9-12
    add_n(5, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);            // 13-17
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b01);            // 18
    add_n(2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 19-20
    // ch1 high for 3 cycles: suppressed.
    add_n(3, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);            // 21-23
    add_n(7, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 24-30
    // ch1 high for 4 cycles: minimum accepted width, then fall.
    add_n(4, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);            // 31-34
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 35
    add  (   1'b0, 2'b00, 2'b10, 2'b10, 2'b00);            // 36
    add_n(3, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00);            // 37-39
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b10);            // 40
    add_n(2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 41-42
    // Bounce train on ch0: one rise, 5 edges after the last 0->1.
    add  (   1'b0, 2'b01, 2'b00, 2'b00, 2'b00);            // 43
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 44
    add  (   1'b0, 2'b01, 2'b00, 2'b00, 2'b00);            // 45
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 46
    add_n(5, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);            // 47-51
    add  (   1'b0, 2'b01, 2'b01, 2'b01, 2'b00);            // 52
    add_n(3, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);            // 53-55
    add_n(5, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);            // 56-60
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b01);            // 61
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 62
    // Independent channels: both rise, ch1 drops after 2 cycles.
    add_n(2, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);            // 63-64
    add_n(3, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);            // 65-67
    add  (   1'b0, 2'b01, 2'b01, 2'b01, 2'b00);            // 68
    add_n(2, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);            // 69-70
    add_n(5, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);            // 71-75
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b01);            // 76
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 77
    // Reset mid-count (cnt[0]=2), din[0] held high; rise 5 edges after release.
    add_n(4, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);            // 78-81
    add  (   1'b1, 2'b01, 2'b00, 2'b00, 2'b00);            // 82
    add_n(5, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);            // 83-87
    add  (   1'b0, 2'b01, 2'b01, 2'b01, 2'b00);            // 88
    add_n(2, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);            // 89-90
    // Reset lands on the edge that would accept a fall: no strobe.
    add_n(5, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);            // 91-95
    add  (   1'b1, 2'b00, 2'b00, 2'b00, 2'b00);            // 96
    add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // 97

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      din = vecs[i].din;
      @(posedge clk);
      #1;
      check_eq($sformatf("dout@%0d", i), 32'(dout), 32'(vecs[i].dout));
      check_eq($sformatf("rise@%0d", i), 32'(rise), 32'(vecs[i].rise));
      check_eq($sformatf("fall@%0d", i), 32'(fall), 32'(vecs[i].fall));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_input_debouncer
`default_nettype wire
